// File: rtl/systolic_sched.sv
// rtl/systolic_sched.sv - phase sequencer for a ROW x COL systolic array
//
// Walks the array through weight preload, skewed input streaming and
// skewed output capture after each accepted start request.
//
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   start            request one pass (accepted only in IDLE, N != 0)
//   num_vectors[5:0] input vectors per pass, latched with start
//   busy             high during LOAD_W and STREAM
//   done             one-cycle pulse when the pass completes
//   w_ps             1 = weight load, 0 = partial-sum accumulate
//   w_row            weight row being loaded during LOAD_W
//   input_en[ROW]    per-row input enable
//   out_en[COL]      per-column output capture enable
//   busy_cycles[16]  saturating busy-cycle counter
//
// Build option: SCHED_PERF_CNT_EN enables the busy_cycles counter;
// when undefined the port is tied to zero.

module systolic_sched #(
   parameter int ROW = 32,
   parameter int COL = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [5:0]              num_vectors,
   output logic                    busy,
   output logic                    done,
   output logic                    w_ps,
   output logic [$clog2(ROW)-1:0]  w_row,
   output logic [ROW-1:0]          input_en,
   output logic [COL-1:0]          out_en,
   output logic [15:0]             busy_cycles
);

   localparam int RW = $clog2(ROW);
   // Wide enough for the largest stream index (63+ROW+COL-2) plus the
   // window upper bounds, so no comparison ever wraps.
   localparam int TW = $clog2(63 + ROW + COL);

   localparam logic [TW-1:0] LOAD_LAST = TW'(ROW - 1);
   localparam logic [TW-1:0] SKEW_SPAN = TW'(ROW + COL - 2);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_W = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   t_q, t_d;
   logic [5:0]      n_q, n_d;
   logic [TW-1:0]   n_ext;

   assign n_ext = TW'(n_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         t_q     <= '0;
         n_q     <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         n_q     <= n_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      n_d     = n_q;
      case (state_q)
         IDLE: begin
            if (start && (num_vectors != 6'd0)) begin
               n_d     = num_vectors;
               t_d     = '0;
               state_d = LOAD_W;
            end
         end
         LOAD_W: begin
            if (t_q == LOAD_LAST) begin
               t_d     = '0;
               state_d = STREAM;
            end else begin
               t_d = t_q + 1'b1;
            end
         end
         STREAM: begin
            // Last stream cycle is t = N+ROW+COL-2: the final column
            // finishes capturing its N-th result there.
            if (t_q == (n_ext + SKEW_SPAN)) begin
               t_d     = '0;
               state_d = DONE;
            end else begin
               t_d = t_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            t_d     = '0;
         end
      endcase
   end

   // Moore outputs, decoded from registered state, t and latched N
   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      w_ps     = 1'b1;
      w_row    = '0;
      input_en = '0;
      out_en   = '0;
      case (state_q)
         LOAD_W: begin
            busy  = 1'b1;
            w_row = t_q[RW-1:0];
         end
         STREAM: begin
            busy = 1'b1;
            w_ps = 1'b0;
            for (int r = 0; r < ROW; r++) begin
               input_en[r] = (t_q >= TW'(r)) && (t_q < (TW'(r) + n_ext));
            end
            for (int c = 0; c < COL; c++) begin
               out_en[c] = (t_q >= TW'(ROW + c)) &&
                           (t_q < (TW'(ROW + c) + n_ext));
            end
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

`ifdef SCHED_PERF_CNT_EN
   logic [15:0] busy_cycles_q, busy_cycles_d;

   always_comb begin
      busy_cycles_d = busy_cycles_q;
      if (busy && (busy_cycles_q != 16'hFFFF)) begin
         busy_cycles_d = busy_cycles_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_cycles_q <= '0;
      end else begin
         busy_cycles_q <= busy_cycles_d;
      end
   end

   assign busy_cycles = busy_cycles_q;
`else
   assign busy_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_systolic_sched.sv
// tb/tb_systolic_sched.sv - scoreboard bench for systolic_sched

module tb_systolic_sched;

   localparam int R = 4;
   localparam int C = 4;

   logic        clk;
   logic        rst4, start4;
   logic [5:0]  num4;
   logic        busy4, done4, w_ps4;
   logic [1:0]  w_row4;
   logic [3:0]  input_en4, out_en4;
   logic [15:0] bc4;

   logic        rst32, start32;
   logic [5:0]  num32;
   logic        busy32, done32, w_ps32;
   logic [4:0]  w_row32;
   logic [31:0] input_en32, out_en32;
   logic [15:0] bc32;

   int n_cmp = 0;
   int n_mis = 0;
   int exp_bc = 0;

   typedef struct {
      int          j;
      logic [12:0] v;
   } exp_t;
   exp_t exp_q[$];

   systolic_sched #(.ROW(R), .COL(C)) dut4 (
      .clk(clk), .rst(rst4), .start(start4), .num_vectors(num4),
      .busy(busy4), .done(done4), .w_ps(w_ps4), .w_row(w_row4),
      .input_en(input_en4), .out_en(out_en4), .busy_cycles(bc4)
   );

   systolic_sched #(.ROW(32), .COL(32)) dut32 (
      .clk(clk), .rst(rst32), .start(start32), .num_vectors(num32),
      .busy(busy32), .done(done32), .w_ps(w_ps32), .w_row(w_row32),
      .input_en(input_en32), .out_en(out_en32), .busy_cycles(bc32)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected {busy,done,w_ps,w_row,input_en,out_en} in cycle j after the
   // start-sampling edge (j=1 is the first LOAD_W cycle); j outside the
   // pass gives the idle value.
   function automatic logic [12:0] exp4(input int j, input int n);
      logic       b, d, wp;
      logic [1:0] wr;
      logic [3:0] ie, oe;
      int         p;
      p  = 2*R + C + n;
      b  = 1'b0; d = 1'b0; wp = 1'b1; wr = 2'd0; ie = '0; oe = '0;
      if (j >= 1 && j <= R) begin
         b  = 1'b1;
         wr = 2'(j - 1);
      end else if (j > R && j < p) begin
         b  = 1'b1;
         wp = 1'b0;
         for (int r = 0; r < R; r++)
            ie[r] = (j >= R + 1 + r) && (j <= R + r + n);
         for (int c = 0; c < C; c++)
            oe[c] = (j >= 2*R + 1 + c) && (j <= 2*R + c + n);
      end else if (j == p) begin
         d = 1'b1;
      end
      return {b, d, wp, wr, ie, oe};
   endfunction

   function automatic logic [12:0] got4();
      return {busy4, done4, w_ps4, w_row4, input_en4, out_en4};
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check_eq($sformatf("cycle_%0d", e.j), 64'(got4()), 64'(e.v));
      end
   end

   task automatic push_idle(input int cnt);
      exp_t e;
      for (int i = 0; i < cnt; i++) begin
         e.j = 0;
         e.v = exp4(0, 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_cycles(input int cnt);
      for (int i = 0; i < cnt; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Starts a pass in the current (idle) cycle; pulses start with random
   // num_vectors in the cycles flagged by ign. Returns in the idle cycle
   // after done, where the next pass may be started back-to-back.
   task automatic run_pass(input int n, input logic [127:0] ign);
      exp_t e;
      int   p;
      p      = 2*R + C + n;
      num4   = 6'(n);
      start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      for (int j = 1; j <= p + 1; j++) begin
         e.j = j;
         e.v = exp4(j, n);
         exp_q.push_back(e);
      end
      for (int j = 1; j <= p; j++) begin
         num4 = 6'($urandom_range(0, 63));
         if (ign[j]) start4 = 1'b1;
         @(posedge clk);
         #1;
         start4 = 1'b0;
      end
`ifdef SCHED_PERF_CNT_EN
      exp_bc = exp_bc + p - 1;
`endif
      check_eq($sformatf("busy_cycles_n%0d", n), 64'(bc4), 64'(exp_bc));
   endtask

   initial begin
      logic [127:0] ign;
      exp_t         e;
      int           j32, busy_cnt;

      rst4 = 1'b1; start4 = 1'b0; num4 = 6'd0;
      rst32 = 1'b1; start32 = 1'b0; num32 = 6'd0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check_eq("reset_outputs", 64'(got4()), 64'(exp4(0, 1)));
         check_eq("reset_busy_cycles", 64'(bc4), 64'd0);
         @(posedge clk);
         #1;
      end
      rst4  = 1'b0;
      rst32 = 1'b0;
      push_idle(10);
      wait_cycles(10);

      // N=0 is rejected
      num4   = 6'd0;
      start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      push_idle(10);
      wait_cycles(10);

      // Stray starts in cycles 2, 6 and 15 are ignored, then back-to-back
      ign = '0;
      ign[2] = 1'b1; ign[6] = 1'b1; ign[15] = 1'b1;
      run_pass(3, ign);
      run_pass(3, '0);
      run_pass(1, '0);
      run_pass(63, '0);
      wait_cycles(2);

      // Reset in the middle of STREAM
      num4   = 6'd3;
      start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      for (int j = 1; j <= R + 3; j++) begin
         e.j = j;
         e.v = exp4(j, 3);
         exp_q.push_back(e);
      end
      wait_cycles(R + 3);
      rst4 = 1'b1;
      #1;
      check_eq("midreset_outputs", 64'(got4()), 64'(exp4(0, 1)));
      check_eq("midreset_busy_cycles", 64'(bc4), 64'd0);
      exp_bc = 0;
      wait_cycles(2);
      rst4 = 1'b0;
      push_idle(3);
      wait_cycles(3);
      run_pass(3, '0);
      wait_cycles(2);

      // ROW=COL=32, N=63: done lands 159 cycles after start
      num32   = 6'd63;
      start32 = 1'b1;
      @(posedge clk);
      #1;
      start32 = 1'b0;
      busy_cnt = 0;
      j32 = 1;
      while (j32 <= 400) begin
         @(negedge clk);
         if (busy32) busy_cnt++;
         if (done32) break;
         j32++;
      end
      check_eq("n63_done_cycle", 64'(j32), 64'd159);
      check_eq("n63_busy_count", 64'(busy_cnt), 64'd158);
`ifdef SCHED_PERF_CNT_EN
      check_eq("n63_busy_cycles", 64'(bc32), 64'd158);
`else
      check_eq("n63_busy_cycles", 64'(bc32), 64'd0);
`endif
      @(posedge clk);
      #1;
      check_eq("n63_idle_busy", 64'(busy32), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
